// File: rtl/inst_cache.sv
// ---------------------------------------------------------------------------
// inst_cache
//
// Direct-mapped, read-only instruction cache between the fetch unit and the
// instruction-side port of the memory controller. A hit is answered
// combinationally in the same cycle as the request. A miss fills the whole
// line from memory one word at a time, starting at word 0. The fetch unit's
// still-held request then hits. Once started, a fill always runs to
// completion, even if the request is withdrawn or the PC changes.
//
// Ports:
//   clk             clock
//   rst             synchronous active-high reset
//   rdy             global ready; low freezes all state and suppresses hits
//   pc_send_enable  fetch request valid
//   pc_to_ic        fetch address (word aligned, bits [1:0] ignored)
//   inst_get_ready  hit indication (combinational)
//   inst_from_ic    instruction word, valid while inst_get_ready is high
//   mem_req_enable  word read request to the memory controller
//   mem_addr        byte address of the requested word
//   mem_ready       one-cycle pulse: mem_word is valid for the current request
//   mem_word        word returned by the memory controller
// ---------------------------------------------------------------------------
module inst_cache #(
  parameter int INDEX_WIDTH    = 6,
  parameter int WORD_OFF_WIDTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        pc_send_enable,
  input  logic [31:0] pc_to_ic,
  output logic        inst_get_ready,
  output logic [31:0] inst_from_ic,
  output logic        mem_req_enable,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_word
);

  localparam int LINES      = 1 << INDEX_WIDTH;
  localparam int LINE_WORDS = 1 << WORD_OFF_WIDTH;
  localparam int LINE_LSB   = 2 + WORD_OFF_WIDTH;
  localparam int TAG_WIDTH  = 32 - LINE_LSB - INDEX_WIDTH;
  localparam int LINE_WIDTH = 32 - LINE_LSB;
  localparam logic [WORD_OFF_WIDTH-1:0] LAST_WORD = WORD_OFF_WIDTH'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GAP,
    COMMIT
  } state_t;

  state_t state;
  state_t state_next;

  // Cache storage: valid bits are reset, tags and data are not.
  logic [LINES-1:0]     valid;
  logic [TAG_WIDTH-1:0] tag_mem  [LINES];
  logic [31:0]          data_mem [LINES][LINE_WORDS];

  // Words of the line being fetched, written into the cache only at commit.
  logic [31:0] fill_buf [LINE_WORDS];

  // Line address (tag + index) of the fill in progress, and the word counter.
  logic [LINE_WIDTH-1:0]     fill_line;
  logic [WORD_OFF_WIDTH-1:0] word_cnt;

  logic [WORD_OFF_WIDTH-1:0] pc_word;
  logic [INDEX_WIDTH-1:0]    pc_index;
  logic [TAG_WIDTH-1:0]      pc_tag;
  logic [INDEX_WIDTH-1:0]    fill_index;
  logic [TAG_WIDTH-1:0]      fill_tag;
  logic                      lookup_hit;
  logic                      start_fill;
  logic                      capture;
  logic                      unused_byte_bits;

  assign pc_word    = pc_to_ic[2 +: WORD_OFF_WIDTH];
  assign pc_index   = pc_to_ic[LINE_LSB +: INDEX_WIDTH];
  assign pc_tag     = pc_to_ic[LINE_LSB + INDEX_WIDTH +: TAG_WIDTH];
  assign fill_index = fill_line[0 +: INDEX_WIDTH];
  assign fill_tag   = fill_line[INDEX_WIDTH +: TAG_WIDTH];

  // Byte offset is meaningless for word-aligned fetches.
  assign unused_byte_bits = ^pc_to_ic[1:0];

  assign lookup_hit = valid[pc_index] && (tag_mem[pc_index] == pc_tag);

  // Lookups are only answered from IDLE, so nothing hits while a fill is in
  // flight, not even a line unrelated to the fill.
  assign inst_get_ready = pc_send_enable && (state == IDLE) && rdy && lookup_hit;
  assign inst_from_ic   = inst_get_ready ? data_mem[pc_index][pc_word] : 32'h0;

  // Memory-side outputs are decoded from the registered state, so they stay
  // stable for the whole REQ phase and hold while rdy is low.
  assign mem_req_enable = (state == REQ);
  assign mem_addr       = (state == REQ) ? {fill_line, word_cnt, 2'b00} : 32'h0;

  assign start_fill = (state == IDLE) && pc_send_enable && !lookup_hit;
  assign capture    = (state == REQ) && mem_ready;

  // Next-state logic. mem_ready outside REQ is simply ignored.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_fill) state_next = REQ;
      REQ:     if (mem_ready) state_next = (word_cnt == LAST_WORD) ? COMMIT : GAP;
      GAP:     state_next = REQ;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control state: reset abandons any fill and leaves every line invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      word_cnt  <= '0;
      valid     <= '0;
      fill_line <= '0;
    end else if (rdy) begin
      state <= state_next;
      if (start_fill) begin
        fill_line <= pc_to_ic[31:LINE_LSB];
        word_cnt  <= '0;
      end
      // The counter stops at the last word rather than wrapping; the last
      // beat is recognised by comparison, not by overflow.
      if (capture && (word_cnt != LAST_WORD)) begin
        word_cnt <= word_cnt + 1'b1;
      end
      if (state == COMMIT) begin
        valid[fill_index] <= 1'b1;
      end
    end
  end

  // Data path storage, no reset needed.
  always_ff @(posedge clk) begin
    if (rdy && !rst) begin
      if (capture) begin
        fill_buf[word_cnt] <= mem_word;
      end
      if (state == COMMIT) begin
        tag_mem[fill_index] <= fill_tag;
        for (int w = 0; w < LINE_WORDS; w++) begin
          data_mem[fill_index][w] <= fill_buf[w];
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// ---------------------------------------------------------------------------
// tb_inst_cache
//
// Directed testbench for inst_cache. A behavioural memory answers each word
// request after a fixed latency. Expected instruction words and expected
// memory request addresses are queued when stimulus is issued; two monitors
// pop and compare whenever the cache presents a hit or starts a new memory
// request.
// ---------------------------------------------------------------------------
module tb_inst_cache;

  localparam int MEM_LATENCY = 2;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        pc_send_enable;
  logic [31:0] pc_to_ic;
  logic        inst_get_ready;
  logic [31:0] inst_from_ic;
  logic        mem_req_enable;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_word;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_inst_q[$];
  logic [31:0] exp_addr_q[$];

  // Memory model controls set by the stimulus process.
  logic corrupt;
  int   spurious_cnt;

  inst_cache #(
    .INDEX_WIDTH   (6),
    .WORD_OFF_WIDTH(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .pc_send_enable(pc_send_enable),
    .pc_to_ic      (pc_to_ic),
    .inst_get_ready(inst_get_ready),
    .inst_from_ic  (inst_from_ic),
    .mem_req_enable(mem_req_enable),
    .mem_addr      (mem_addr),
    .mem_ready     (mem_ready),
    .mem_word      (mem_word)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-chosen memory contents.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    case (a)
      32'h000: return 32'h11;
      32'h004: return 32'h22;
      32'h008: return 32'h33;
      32'h00C: return 32'h44;
      32'h400: return 32'hA0;
      32'h404: return 32'hA1;
      32'h408: return 32'hA2;
      32'h40C: return 32'hA3;
      default: return {16'hC0DE, a[15:0]};
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Expect one full line fill starting at word 0.
  task automatic pushLine(input logic [31:0] base);
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(base + 32'(4 * i));
  endtask

  // Issue a fetch and hold it until it is answered (bounded). exp_hit is the
  // expected inst_get_ready in the first cycle of the request.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] exp_val,
                               input logic exp_hit);
    int n;
    pc_to_ic       = addr;
    pc_send_enable = 1'b1;
    exp_inst_q.push_back(exp_val);
    @(negedge clk);
    checkOutput($sformatf("first_cycle_hit@%0h", addr), {31'b0, inst_get_ready}, {31'b0, exp_hit});
    n = 0;
    while (!inst_get_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!inst_get_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL fetch_timeout@%0h: actual=no_hit required=hit", addr);
      void'(exp_inst_q.pop_front());
    end
    @(posedge clk);
    #1;
    pc_send_enable = 1'b0;
  endtask

  // Wait (bounded) until the cache is requesting a given word from memory.
  task automatic waitMemAddr(input logic [31:0] addr);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mem_req_enable && mem_addr == addr) && n < 300);
    if (!(mem_req_enable && mem_addr == addr)) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_mem_addr: actual=0x%0h required=0x%0h", mem_addr, addr);
    end
  endtask

  // Memory model: answers a request after MEM_LATENCY cycles with a one-cycle
  // pulse. If the request is still up after the pulse (rdy was low) the
  // model starts over and pulses again.
  int wait_cnt = 0;
  bit pulsed   = 0;
  int spurious_done = 0;
  always @(negedge clk) begin
    mem_ready = 1'b0;
    mem_word  = 32'h0;
    if (spurious_cnt != spurious_done) begin
      spurious_done++;
      mem_ready = 1'b1;
      mem_word  = 32'hBAD0BAD0;
    end else if (mem_req_enable) begin
      if (pulsed) begin
        pulsed   = 0;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
        if (wait_cnt >= MEM_LATENCY) begin
          mem_ready = 1'b1;
          mem_word  = corrupt ? 32'hDEADBEEF : mem_val(mem_addr);
          pulsed    = 1;
        end
      end
    end else begin
      wait_cnt = 0;
      pulsed   = 0;
    end
  end

  // Hit monitor.
  always @(negedge clk) begin
    if (inst_get_ready) begin
      if (exp_inst_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_hit: actual=pc 0x%0h data 0x%0h required=no_hit",
                 pc_to_ic, inst_from_ic);
      end else begin
        checkOutput($sformatf("inst_data@%0h", pc_to_ic), inst_from_ic, exp_inst_q.pop_front());
      end
    end
  end

  // Memory request monitor: order, one-cycle gaps between words, stability.
  logic        prev_req = 1'b0;
  logic [31:0] held_addr = 32'h0;
  int          low_run = 100;
  always @(negedge clk) begin
    if (mem_req_enable && !prev_req) begin
      if (exp_addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_mem_req: actual=0x%0h required=none", mem_addr);
      end else begin
        checkOutput("mem_req_addr", mem_addr, exp_addr_q.pop_front());
      end
      if (mem_addr[3:2] != 2'b00) checkOutput("gap_cycles", 32'(low_run), 32'd1);
      held_addr = mem_addr;
      low_run   = 0;
    end else if (mem_req_enable) begin
      checkOutput("mem_addr_stable", mem_addr, held_addr);
    end else begin
      low_run++;
    end
    prev_req = mem_req_enable;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    rdy            = 1'b1;
    pc_send_enable = 1'b0;
    pc_to_ic       = 32'h0;
    corrupt        = 1'b0;
    spurious_cnt   = 0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_inst_ready", {31'b0, inst_get_ready}, 32'd0);
    checkOutput("reset_mem_req", {31'b0, mem_req_enable}, 32'd0);
    checkOutput("reset_mem_addr", mem_addr, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: cold miss on line 0, then hits with no memory traffic.
    $display("[TB] test 1: cold fill of 0x0");
    pushLine(32'h0);
    applyStimulus(32'h0, 32'h11, 1'b0);
    applyStimulus(32'hC, 32'h44, 1'b1);
    applyStimulus(32'h8, 32'h33, 1'b1);

    // 2: conflicting tag at the same index evicts and refills.
    $display("[TB] test 2: conflict at index 0");
    pushLine(32'h400);
    applyStimulus(32'h400, 32'hA0, 1'b0);
    applyStimulus(32'h40C, 32'hA3, 1'b1);
    pushLine(32'h0);
    applyStimulus(32'h0, 32'h11, 1'b0);

    // 3: request withdrawn mid-fill; the fill still commits.
    $display("[TB] test 3: fill survives a jump");
    pushLine(32'h100);
    pushLine(32'h200);
    pc_to_ic       = 32'h100;
    pc_send_enable = 1'b1;
    @(negedge clk);
    checkOutput("t3_first_cycle_hit", {31'b0, inst_get_ready}, 32'd0);
    waitMemAddr(32'h108);
    @(posedge clk);
    #1;
    pc_send_enable = 1'b0;
    pc_to_ic       = 32'h200;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(32'h200, mem_val(32'h200), 1'b0);
    applyStimulus(32'h104, mem_val(32'h104), 1'b1);
    applyStimulus(32'h10C, mem_val(32'h10C), 1'b1);

    // 4: rdy low in the middle of a word request.
    $display("[TB] test 4: rdy freeze during fill");
    pushLine(32'h300);
    fork
      applyStimulus(32'h300, mem_val(32'h300), 1'b0);
      begin
        waitMemAddr(32'h304);
        @(posedge clk);
        #1;
        rdy     = 1'b0;
        corrupt = 1'b1;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          checkOutput("t4_frozen_req", {31'b0, mem_req_enable}, 32'd1);
          checkOutput("t4_frozen_addr", mem_addr, 32'h304);
          checkOutput("t4_no_hit", {31'b0, inst_get_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        rdy     = 1'b1;
        corrupt = 1'b0;
      end
    join
    applyStimulus(32'h304, mem_val(32'h304), 1'b1);
    // A valid line still reports no hit while rdy is low.
    rdy = 1'b0;
    fork
      applyStimulus(32'h308, mem_val(32'h308), 1'b0);
      begin
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rdy = 1'b1;
      end
    join

    // 5: reset during word 2 of a fill; the fill restarts from word 0.
    $display("[TB] test 5: reset mid-fill");
    exp_addr_q.push_back(32'h40);
    exp_addr_q.push_back(32'h44);
    exp_addr_q.push_back(32'h48);
    pushLine(32'h40);
    fork
      applyStimulus(32'h40, mem_val(32'h40), 1'b0);
      begin
        waitMemAddr(32'h48);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t5_req_after_reset", {31'b0, mem_req_enable}, 32'd0);
        checkOutput("t5_no_hit_after_reset", {31'b0, inst_get_ready}, 32'd0);
      end
    join

    // 6: stray mem_ready in IDLE must not validate anything.
    $display("[TB] test 6: spurious mem_ready");
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    spurious_cnt++;
    repeat (3) @(posedge clk);
    #1;
    pushLine(32'h0);
    applyStimulus(32'h0, 32'h11, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
    checkOutput("inst_queue_drained", 32'(exp_inst_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
